// File: rtl/encounter_roll_pkg.sv
// Shared types and helpers for the wild-encounter generator.
package encounter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROLL_ENC,
    ROLL_SPC,
    ROLL_LVL,
    PRESENT
  } enc_state_t;

  localparam int unsigned LVL_W = 7;

  // Species index width; a single bit is kept even for two species.
  function automatic int unsigned spc_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/encounter_roll_rand_draw.sv
// One random draw: holds rnd_en for SKIP cycles and strobes sample on the last,
// when the LFSR output is the value to consume (before that edge's advance).
module rand_draw #(
  parameter int unsigned SKIP = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic rnd_en,
  output logic sample
);

  localparam int unsigned CNT_W = (SKIP <= 2) ? 1 : $clog2(SKIP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SKIP - 1);

  logic [CNT_W-1:0] cnt;

  // start is held for as long as draws are wanted; back-to-back draws just wrap.
  assign rnd_en = start && !abort;
  assign sample = rnd_en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!rnd_en || sample) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/encounter_roll.sv
// Wild-encounter generator: on a grass step, draws encounter/species/level bytes
// from the LFSR and presents the result over a valid/ready handshake.
module encounter_roll
  import encounter_pkg::*;
#(
  parameter int unsigned NUM_SPECIES = 6,
  parameter int unsigned ENC_RATE    = 26,
  parameter int unsigned LVL_MIN     = 2,
  parameter int unsigned LVL_SPAN    = 4,
  parameter int unsigned DRAW_SKIP   = 8,
  parameter int unsigned SAFE_STEPS  = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                step,
  input  logic                                in_grass,
  input  logic [7:0]                          rnd,
  output logic                                rnd_en,
  output logic                                busy,
  output logic                                enc_valid,
  input  logic                                enc_ready,
  output logic [spc_width(NUM_SPECIES)-1:0]   enc_species,
  output logic [LVL_W-1:0]                    enc_level
);

  localparam int unsigned SPC_W = spc_width(NUM_SPECIES);
  localparam int unsigned CD_W  = (SAFE_STEPS < 2) ? 1 : $clog2(SAFE_STEPS + 1);

  generate
    if (NUM_SPECIES < 2 || NUM_SPECIES > 8) begin : g_bad_species
      $error("encounter_roll: NUM_SPECIES must be 2..8");
    end
    if (LVL_SPAN < 1 || LVL_SPAN > 64 || (LVL_SPAN & (LVL_SPAN - 1)) != 0) begin : g_bad_span
      $error("encounter_roll: LVL_SPAN must be a power of two in 1..64");
    end
    if (LVL_MIN + LVL_SPAN - 1 > 127) begin : g_bad_level
      $error("encounter_roll: highest level exceeds 127");
    end
    if (DRAW_SKIP < 1) begin : g_bad_skip
      $error("encounter_roll: DRAW_SKIP must be at least 1");
    end
  endgenerate

  enc_state_t       state, state_nxt;
  logic [CD_W-1:0]  cooldown, cooldown_nxt;
  logic [SPC_W-1:0] species_q, species_nxt;
  logic [LVL_W-1:0] level_q, level_nxt;

  logic draw_run;
  logic draw_abort;
  logic sample;
  logic enc_hit;
  logic spc_ok;
  logic [LVL_W-1:0] lvl_calc;

  assign draw_run   = (state == ROLL_ENC) || (state == ROLL_SPC) || (state == ROLL_LVL);
  assign draw_abort = (state == IDLE);

  rand_draw #(
    .SKIP (DRAW_SKIP)
  ) u_draw (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (draw_run),
    .abort  (draw_abort),
    .rnd_en (rnd_en),
    .sample (sample)
  );

  assign enc_hit  = 32'(rnd) < ENC_RATE;
  assign spc_ok   = 32'(rnd[SPC_W-1:0]) < NUM_SPECIES;
  assign lvl_calc = LVL_W'(LVL_MIN) + (LVL_W'(rnd) & LVL_W'(LVL_SPAN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cooldown  <= '0;
      species_q <= '0;
      level_q   <= '0;
    end else begin
      state     <= state_nxt;
      cooldown  <= cooldown_nxt;
      species_q <= species_nxt;
      level_q   <= level_nxt;
    end
  end

  // A rejected species draw stays in ROLL_SPC, so the draw unit keeps rnd_en high.
  always_comb begin
    state_nxt    = state;
    cooldown_nxt = cooldown;
    species_nxt  = species_q;
    level_nxt    = level_q;
    case (state)
      IDLE: begin
        if (step && in_grass) begin
          if (cooldown != '0) begin
            cooldown_nxt = cooldown - 1'b1;
          end else begin
            state_nxt = ROLL_ENC;
          end
        end
      end
      ROLL_ENC: begin
        if (sample) begin
          state_nxt = enc_hit ? ROLL_SPC : IDLE;
        end
      end
      ROLL_SPC: begin
        if (sample && spc_ok) begin
          species_nxt = rnd[SPC_W-1:0];
          state_nxt   = ROLL_LVL;
        end
      end
      ROLL_LVL: begin
        if (sample) begin
          level_nxt = lvl_calc;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (enc_ready) begin
          cooldown_nxt = CD_W'(SAFE_STEPS);
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign enc_valid   = (state == PRESENT);
  assign enc_species = species_q;
  assign enc_level   = level_q;

endmodule

// File: tb/tb_encounter_roll.sv
// Randomized bench for encounter_roll against a draw-level reference model.
module tb_encounter_roll;

  localparam int unsigned NUM_SPECIES = 6;
  localparam int unsigned ENC_RATE    = 26;
  localparam int unsigned LVL_MIN     = 2;
  localparam int unsigned LVL_SPAN    = 4;
  localparam int unsigned DRAW_SKIP   = 8;
  localparam int unsigned SAFE_STEPS  = 3;
  localparam int unsigned SPC_MOD     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step = 1'b0;
  logic       in_grass = 1'b0;
  logic       enc_ready = 1'b0;
  logic [7:0] rnd;
  logic       rnd_en;
  logic       busy;
  logic       enc_valid;
  logic [2:0] enc_species;
  logic [6:0] enc_level;

  encounter_roll #(
    .NUM_SPECIES (NUM_SPECIES),
    .ENC_RATE    (ENC_RATE),
    .LVL_MIN     (LVL_MIN),
    .LVL_SPAN    (LVL_SPAN),
    .DRAW_SKIP   (DRAW_SKIP),
    .SAFE_STEPS  (SAFE_STEPS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step),
    .in_grass    (in_grass),
    .rnd         (rnd),
    .rnd_en      (rnd_en),
    .busy        (busy),
    .enc_valid   (enc_valid),
    .enc_ready   (enc_ready),
    .enc_species (enc_species),
    .enc_level   (enc_level)
  );

  always #5 clk = ~clk;

  // Entropy source: either an 8-bit maximal LFSR or a directed list of draw values.
  logic        lfsr_mode = 1'b0;
  logic [7:0]  src_lfsr = 8'h01;
  int unsigned adv_cnt = 0;
  int unsigned dir_base = 0;
  int unsigned rnd_idx;
  logic [7:0]  dir_arr [16];

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  always @(posedge clk) begin
    if (rnd_en) begin
      adv_cnt <= adv_cnt + 1;
      if (lfsr_mode) src_lfsr <= lfsr_next(src_lfsr);
    end
  end

  always_comb begin
    rnd_idx = (adv_cnt - dir_base) / DRAW_SKIP;
    rnd = lfsr_mode ? src_lfsr : ((rnd_idx < 16) ? dir_arr[rnd_idx] : 8'hFF);
  end

  // Reference model state
  logic [7:0] m_lfsr;
  int         m_idx;
  int         m_cd;
  logic [2:0] m_spc;
  logic [6:0] m_lvl;
  int         rolls = 0;
  int         m_hits = 0;
  int         dut_hits = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dir(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                         input logic [7:0] v3, input logic [7:0] v4, input logic [7:0] fill);
    for (int i = 0; i < 16; i++) dir_arr[i] = fill;
    dir_arr[0] = v0; dir_arr[1] = v1; dir_arr[2] = v2; dir_arr[3] = v3; dir_arr[4] = v4;
    dir_base  = adv_cnt;
    m_idx     = 0;
    lfsr_mode = 1'b0;
  endtask

  // One draw as seen by the consumer: the value on the last of DRAW_SKIP advance cycles.
  task automatic mdraw(output logic [7:0] v);
    if (lfsr_mode) begin
      v = m_lfsr;
      for (int i = 0; i < DRAW_SKIP; i++) begin
        v = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
      end
    end else begin
      v = (m_idx < 16) ? dir_arr[m_idx] : 8'hFF;
      m_idx++;
    end
  endtask

  task automatic predict(output bit hit, output int draws, output logic [2:0] spc, output logic [6:0] lvl);
    logic [7:0] v;
    draws = 0;
    spc = m_spc;
    lvl = m_lvl;
    mdraw(v);
    draws++;
    hit = (v < ENC_RATE);
    if (!hit) return;
    do begin
      mdraw(v);
      draws++;
    end while ((v % SPC_MOD) >= NUM_SPECIES && draws < 300);
    spc = 3'(v % SPC_MOD);
    mdraw(v);
    draws++;
    lvl = 7'(LVL_MIN + (v % LVL_SPAN));
  endtask

  task automatic run_roll(input bit hit, input int draws, input logic [2:0] spc, input logic [6:0] lvl);
    int c = 1;
    int en = 0;
    bit timeout = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (enc_valid || !busy) begin
        timeout = 1'b0;
        break;
      end
      if (rnd_en) en++;
      tick();
      c++;
    end
    check("roll_timeout", timeout, 0);
    check("roll_valid", enc_valid, hit);
    check("roll_latency", c, 1 + draws * DRAW_SKIP);
    check("rnd_en_cycles", en, draws * DRAW_SKIP);
    check("roll_species", enc_species, spc);
    check("roll_level", enc_level, lvl);
    check("roll_rnd_en_end", rnd_en, 0);
    if (enc_valid) dut_hits++;
  endtask

  task automatic present_hold(input int n);
    for (int i = 0; i < n; i++) begin
      enc_ready = 1'b0;
      step      = 1'($urandom_range(0, 1));
      in_grass  = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", enc_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_rnd_en", rnd_en, 0);
      check("hold_species", enc_species, m_spc);
      check("hold_level", enc_level, m_lvl);
    end
    step      = 1'b0;
    in_grass  = 1'b0;
    enc_ready = 1'b1;
    tick();
    enc_ready = 1'b0;
    check("accept_valid", enc_valid, 0);
    check("accept_busy", busy, 0);
    check("accept_species", enc_species, m_spc);
    check("accept_level", enc_level, m_lvl);
  endtask

  task automatic grass_step(input bit grass, input int hold);
    bit hit;
    int draws;
    logic [2:0] spc;
    logic [6:0] lvl;
    step     = 1'b1;
    in_grass = grass;
    tick();
    step     = 1'b0;
    in_grass = 1'b0;
    if (grass && m_cd == 0) begin
      predict(hit, draws, spc, lvl);
      rolls++;
      run_roll(hit, draws, spc, lvl);
      if (hit) begin
        m_hits++;
        m_spc = spc;
        m_lvl = lvl;
        present_hold(hold);
        m_cd = SAFE_STEPS;
      end
    end else begin
      if (grass) m_cd--;
      check("step_ignored", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_cd  = 0;
    m_spc = '0;
    m_lvl = '0;
    repeat (3) tick();
    check("rst_rnd_en", rnd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", enc_valid, 0);
    check("rst_species", enc_species, 0);
    check("rst_level", enc_level, 0);
    rst_n = 1'b1;
    tick();

    // Miss at the threshold value, then a clean hit.
    set_dir(8'd26, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF);
    grass_step(1'b1, 0);
    set_dir(8'd25, 8'd3, 8'd2, 8'd0, 8'd0, 8'hFF);
    grass_step(1'b1, 0);
    grass_step(1'b1, 0);
    grass_step(1'b0, 0);
    grass_step(1'b1, 0);
    grass_step(1'b1, 0);

    // Species rejects (7, low bits 6) then backpressure with dropped steps.
    set_dir(8'd0, 8'h07, 8'h0E, 8'h05, 8'h01, 8'hFF);
    grass_step(1'b1, 10);
    grass_step(1'b1, 0);
    grass_step(1'b0, 0);
    grass_step(1'b1, 0);
    grass_step(1'b1, 0);
    set_dir(8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF);
    grass_step(1'b1, 0);

    // Asynchronous reset while stuck rejecting species.
    set_dir(8'd0, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07);
    step     = 1'b1;
    in_grass = 1'b1;
    tick();
    step     = 1'b0;
    in_grass = 1'b0;
    repeat (DRAW_SKIP + 3) tick();
    check("spc_busy", busy, 1);
    check("spc_rnd_en", rnd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rnd_en", rnd_en, 0);
    check("async_busy", busy, 0);
    check("async_valid", enc_valid, 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    m_cd  = 0;
    m_spc = '0;
    m_lvl = '0;
    check("post_rst_species", enc_species, 0);
    check("post_rst_level", enc_level, 0);
    grass_step(1'b0, 0);

    // Randomized walk driven by the LFSR source.
    lfsr_mode = 1'b1;
    m_lfsr    = src_lfsr;
    rolls     = 0;
    m_hits    = 0;
    dut_hits  = 0;
    for (int n = 0; n < 1000; n++) begin
      grass_step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) tick();
    end
    check("hit_count", dut_hits, m_hits);
    check("enc_rate_band", (dut_hits * 100 >= rolls * 5) && (dut_hits * 100 <= rolls * 15), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
